iface_data_arbiter: RTL
=======================

// Module: iface_data_arbiter
// PURPOSE
//   Shares the single 8-bit data output of the clocked data interface among NUM_REQ requesters.
//   Round-robin grant, packet-oriented: a grant is held until the requester's last beat, a burst cap, or an idle timeout.
//   Output is registered with a valid/ready handshake, so the interface data port is driven glitch-free.
//   Sits between the requester blocks and the interface instance. o_data feeds the interface data input.
// PARAMETERS
//   NUM_REQ      4   number of requesters (2..8)
//   WIDTH        8   data width; must equal the interface data width
//   MAX_BURST    4   max beats accepted per grant (1..15)
//   IDLE_TIMEOUT 8   cycles without valid from the granted requester before the grant is revoked (1..255)
// PORTS
//   i_clk         in   1                clock; all logic on posedge
//   i_rst         in   1                synchronous, active-high reset
//   i_req_valid   in   NUM_REQ          per-requester beat valid
//   i_req_data    in   NUM_REQ x WIDTH  per-requester beat data
//   i_req_last    in   NUM_REQ          marks the final beat of a packet
//   o_req_ready   out  NUM_REQ          beat accepted from requester n when valid[n] & ready[n]
//   o_data        out  WIDTH            registered output data, to the interface
//   o_data_valid  out  1                o_data holds an unconsumed beat
//   i_data_ready  in   1                downstream consumes o_data when valid & ready
//   o_grant       out  NUM_REQ          one-hot current grant; all zero in IDLE
//   o_busy        out  1                state != IDLE
// BEHAVIOUR
//   Reset values
//     o_data=0, o_data_valid=0, o_grant=0, o_busy=0, o_req_ready=0.
//     state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has first priority), beat_cnt=0, idle_cnt=0.
//   Reset mid-operation
//     Any in-flight beat in o_data is dropped.
//     All state returns to reset values on the next edge.
//   FSM IDLE
//     If any i_req_valid is set: pick the first valid index searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//     Register the pick in o_grant and go to XFER. Grant latency is 1 cycle after the request is seen.
//     No beats are accepted in IDLE.
//   FSM XFER
//     o_req_ready[g] = o_grant[g] & (~o_data_valid | i_data_ready); ready is 0 for all other requesters.
//     On accept: o_data <= i_req_data[g], o_data_valid <= 1, beat_cnt++, idle_cnt <= 0.
//     Output: o_data_valid clears on i_data_ready when no new beat is accepted in the same cycle.
//     If the output register is full and stalled, the requester sees ready=0 and no beat is lost or duplicated.
//     If i_req_valid[g]=0 in a cycle: idle_cnt++.
//   Grant release (to IDLE, rr_ptr <= g, o_grant <= 0) when either:
//     (a) the accepted beat has i_req_last=1;
//     (b) the accepted beat brings beat_cnt to MAX_BURST;
//     (c) idle_cnt reaches IDLE_TIMEOUT.
//   Release does not flush o_data: a pending beat still drains through the handshake.
//   After release there is always one IDLE cycle before the next grant.
//   Simultaneous events
//     last and burst cap in the same beat: a single release.
//     Release and a new request in the same cycle: the new request is arbitrated in the IDLE cycle.
//     The releasing requester has lowest priority in the next arbitration.
//   Widths
//     beat_cnt is 4 bits, idle_cnt is 8 bits; both saturate and never wrap.
//     rr_ptr is $clog2(NUM_REQ) bits and wraps NUM_REQ-1 -> 0.
// STRUCTURE
//   Package iface_arb_pkg: typedef enum logic {IDLE, XFER} arb_state_e; beat_cnt_t; idle_cnt_t.
//   Sub-module rr_pick: combinational round-robin priority picker.
//     Inputs: req vector and pointer. Outputs: one-hot grant and any_req.
//     Instantiated once.
//   Top level: FSM, counters, output register, ready generation.
// TESTING
//   1. Reset: hold i_rst 3 cycles with all valids high -> o_grant=0, o_data_valid=0, o_req_ready=0.
//   2. Single packet: req0 sends 0x11,0x22,0x33 (last on 0x33), i_data_ready=1.
//      -> grant=0001 one cycle after valid; o_data 0x11,0x22,0x33 on consecutive cycles; then IDLE.
//   3. Round-robin: req0..req3 all valid, 1-beat packets.
//      -> grants in order 0001,0010,0100,1000,0001, each separated by one IDLE cycle.
//   4. Burst cap: req1 streams 6 beats with no last, MAX_BURST=4.
//      -> grant released after the 4th beat; req2 (also pending) is granted next; req1 re-granted later for beats 5-6.
//   5. Backpressure: i_data_ready=0 for 5 cycles during req0's packet.
//      -> o_data stable, o_req_ready[0]=0, no beat lost or duplicated. Scoreboard compares the sequence.
//   6. Timeout and mid-op reset: granted req2 drops valid for 8 cycles -> grant revoked, req3 granted.
//      Then assert i_rst mid-beat -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/iface_arb_pkg.sv
// Shared types and saturating counter helpers for the interface data arbiter.
package iface_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    typedef logic [3:0] beat_cnt_t;
    typedef logic [7:0] idle_cnt_t;

    localparam beat_cnt_t BEAT_CNT_MAX = 4'hF;
    localparam idle_cnt_t IDLE_CNT_MAX = 8'hFF;

    function automatic beat_cnt_t beat_inc(input beat_cnt_t v);
        return (v == BEAT_CNT_MAX) ? v : v + 4'd1;
    endfunction

    function automatic idle_cnt_t idle_inc(input idle_cnt_t v);
        return (v == IDLE_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/iface_data_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i (wrapping) wins.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               any_req_o
);

    logic          found_s;
    logic          hit_s;
    logic [PW-1:0] idx_s;

    // Walk ptr+1, ptr+2, ... so the requester at ptr_i is considered last.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s          = PW'((int'(ptr_i) + i) % NUM_REQ);
            hit_s          = req_i[idx_s] & ~found_s;
            grant_o[idx_s] = grant_o[idx_s] | hit_s;
            found_s        = found_s | hit_s;
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/iface_data_arbiter.sv
// Packet-oriented round-robin arbiter sharing one registered valid/ready data
// output among NUM_REQ requesters; grants end on last beat, burst cap or idle timeout.
module iface_data_arbiter
    import iface_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]       i_req_last,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_data_valid,
    input  logic                     i_data_ready,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_busy
);

    localparam int            PW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam beat_cnt_t     MAX_BURST_C = beat_cnt_t'(MAX_BURST);
    localparam idle_cnt_t     TIMEOUT_C   = idle_cnt_t'(IDLE_TIMEOUT);
    localparam logic [PW-1:0] PTR_RST_C   = PW'(NUM_REQ - 1);

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    beat_cnt_t            beat_cnt_q, beat_cnt_d;
    idle_cnt_t            idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 data_valid_q, data_valid_d;

    logic [NUM_REQ-1:0]   pick_s;
    logic                 any_req_s;
    logic [NUM_REQ-1:0]   ready_s;
    logic                 accept_s;
    logic                 last_s;
    logic                 gvalid_s;
    logic                 release_s;
    logic [WIDTH-1:0]     gdata_s;
    logic [PW-1:0]        gidx_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_pick (
        .req_i     (i_req_valid),
        .ptr_i     (rr_ptr_q),
        .grant_o   (pick_s),
        .any_req_o (any_req_s)
    );

    // Mux the granted requester's data and index out of the one-hot grant.
    always_comb begin
        gdata_s = '0;
        gidx_s  = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            gdata_s = gdata_s | (i_req_data[n*WIDTH +: WIDTH] & {WIDTH{grant_q[n]}});
            gidx_s  = gidx_s | (PW'(n) & {PW{grant_q[n]}});
        end
    end

    // Ready only to the granted requester, and only when the output slot frees.
    always_comb begin
        if (state_q == XFER) begin
            ready_s = grant_q & {NUM_REQ{~data_valid_q | i_data_ready}};
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s = |(ready_s & i_req_valid);
    assign gvalid_s = |(grant_q & i_req_valid);
    assign last_s   = |(grant_q & i_req_last);

    // Arbitration FSM with burst and idle counters.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        release_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    grant_d = pick_s;
                    state_d = XFER;
                end else begin
                    grant_d = '0;
                end
                beat_cnt_d = '0;
                idle_cnt_d = '0;
            end
            XFER: begin
                if (accept_s) begin
                    beat_cnt_d = beat_inc(beat_cnt_q);
                    idle_cnt_d = '0;
                    release_s  = last_s | (beat_cnt_d >= MAX_BURST_C);
                end else if (!gvalid_s) begin
                    idle_cnt_d = idle_inc(idle_cnt_q);
                    release_s  = (idle_cnt_d >= TIMEOUT_C);
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
                if (release_s) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    rr_ptr_d   = gidx_s;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end else begin
                    state_d = XFER;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output slot: load on accept, otherwise drain on downstream ready.
    always_comb begin
        data_d       = data_q;
        data_valid_d = data_valid_q;
        if (accept_s) begin
            data_d       = gdata_s;
            data_valid_d = 1'b1;
        end else if (i_data_ready) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= PTR_RST_C;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign o_req_ready  = ready_s;
    assign o_data       = data_q;
    assign o_data_valid = data_valid_q;
    assign o_grant      = grant_q;
    assign o_busy       = (state_q == XFER);

endmodule
